uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo_mem.sv | 44 ++++
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants: byte width, default RX FIFO depth and
//            the status-bit layout seen by the 8251-style register port.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int RX_FIFO_DEPTH_DEF  = 16;

    localparam int STAT_TDRE_BIT      = 0;
    localparam int STAT_RX_VALID_BIT  = 1;
    localparam int STAT_OVERRUN_BIT   = 2;
    localparam int STAT_RX_FULL_BIT   = 3;

    typedef logic [BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_mem
// Brief    : Simple dual-port byte array, synchronous write, registered read.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  uart_byte_t        wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output uart_byte_t        rdata_o
);

    uart_byte_t mem_q [DEPTH];
    uart_byte_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register is the CPU-visible data_out, so it alone carries a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive byte FIFO with count/full/valid status and sticky
//            overrun; irq built only when UART_RX_FIFO_IRQ_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH_DEF,
    parameter int THRESH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BYTE_W-1:0]         rx_data,
    input  logic                      rx_strobe,
    input  logic                      rd,
    output logic [BYTE_W-1:0]         data_out,
    output logic                      valid,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overrun,
    input  logic                      clr_ovr,
    output logic                      irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || THRESH < 1 || THRESH > DEPTH) begin : g_param_chk
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and THRESH in 1..DEPTH");
    end

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, full_q, overrun_q, overrun_d;
    logic          w_push, w_pop, w_drop;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        w_pop     = rd && (count_q != '0);
        w_push    = rx_strobe && (!full_q || w_pop);
        w_drop    = rx_strobe && !w_push;
        wp_d      = w_push ? wp_q + 1'b1 : wp_q;
        rp_d      = w_pop  ? rp_q + 1'b1 : rp_q;
        count_d   = count_q + CW'(w_push) - CW'(w_pop);
        overrun_d = w_drop ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            valid_q   <= (count_d != '0);
            full_q    <= (count_d == CW'(DEPTH));
            overrun_q <= overrun_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_push && !reset),
        .waddr_i (wp_q),
        .wdata_i (rx_data),
        .re_i    (w_pop && !reset),
        .raddr_i (rp_q),
        .rdata_o (data_out)
    );

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (count_d >= CW'(THRESH)) || overrun_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign valid   = valid_q;
    assign full    = full_q;
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo (DEPTH=16, THRESH=8).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rd;
    logic       clr_ovr;
    logic [7:0] data_out;
    logic       valid;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    logic       rd_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .rd        (rd),
        .data_out  (data_out),
        .valid     (valid),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every rd accepted at an edge produces a data_out to score.
    always @(posedge clk) rd_prev <= rd && !reset;

    always @(negedge clk) begin
        if (rd_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL data_out: got %0h with no expected entry queued", data_out);
            end else begin
                chk("data_out", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
        rx_strobe = s; rx_data = d; rd = r; clr_ovr = c;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [7:0] e);
        exp_q.push_back(e);
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic status(input int c, input logic o);
        logic exp_irq;
`ifdef UART_RX_FIFO_IRQ_EN
        exp_irq = (c >= 8) || o;
`else
        exp_irq = 1'b0;
`endif
        chk("count",   {27'h0, count},   c);
        chk("valid",   {31'h0, valid},   {31'h0, c != 0});
        chk("full",    {31'h0, full},    {31'h0, c == 16});
        chk("overrun", {31'h0, overrun}, {31'h0, o});
        chk("irq",     {31'h0, irq},     {31'h0, exp_irq});
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_strobe = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_data_out", {24'h0, data_out}, 32'h0);
        status(0, 1'b0);

        // Single byte round trip
        push(8'h41);
        status(1, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        pop(8'h41);
        status(0, 1'b0);

        // Fill, drop one, drain in order
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            status(i + 1, 1'b0);
        end
        push(8'hAA);
        status(16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            pop(8'(i));
            status(15 - i, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        status(0, 1'b0);

        // rd on empty holds the last byte
        pop(8'h0F);
        status(0, 1'b0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) push(8'(i));
        status(16, 1'b0);
        exp_q.push_back(8'h00);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        status(16, 1'b0);
        for (int i = 1; i < 16; i++) pop(8'(i));
        pop(8'h55);
        status(0, 1'b0);

        // Set beats clear in the same cycle
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        push(8'hAB);
        status(16, 1'b1);
        step(1'b1, 8'h66, 1'b0, 1'b1);
        status(16, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        status(16, 1'b0);

        // Reset mid-operation with coincident strobe and rd
        reset = 1'b1; rx_strobe = 1'b1; rd = 1'b1; rx_data = 8'h99;
        @(posedge clk);
        #1 reset = 1'b0; rx_strobe = 1'b0; rd = 1'b0;
        chk("midreset_data_out", {24'h0, data_out}, 32'h0);
        status(0, 1'b0);

        // Push and pop on empty: pop ignored
        exp_q.push_back(8'h00);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        status(1, 1'b0);
        pop(8'h77);
        status(0, 1'b0);

        // Threshold crossing
        for (int i = 0; i < 8; i++) begin
            push(8'(8'hA0 + i));
            status(i + 1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            pop(8'(8'hA0 + i));
            status(7 - i, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
